// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: periodic pack-strobe scheduler and bus/switch direction arbiter
// for the IR packet generator, with completion tracking and sticky error flags.
// Optional build macro: DIR_SANITIZE_EN -- clears contradictory direction bit
// pairs (right+left, backward+forward) in the word latched for each packet.
module ir_tx_scheduler #(
  parameter int unsigned PERIOD_CYCLES = 5000000,
  parameter int unsigned TX_TIMEOUT    = 4000000,
  parameter int unsigned HOLD_PACKETS  = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_bus_we,
  input  logic [3:0] i_bus_dir,
  input  logic [3:0] i_sw_dir,
  input  logic       i_pkt_done,
  input  logic       i_err_clr,
  output logic       o_pack_strobe,
  output logic [3:0] o_dir_state,
  output logic       o_busy,
  output logic       o_src_bus,
  output logic [7:0] o_pkt_count,
  output logic       o_overrun,
  output logic       o_timeout_err
);

  localparam logic [23:0] LP_PER_LAST = 24'(PERIOD_CYCLES - 1);
  localparam logic [23:0] LP_TO_LAST  = 24'(TX_TIMEOUT - 1);
  localparam logic [3:0]  LP_HOLD     = 4'(HOLD_PACKETS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STROBE = 2'd2,
    S_TX     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_per_cnt;
  logic [23:0] r_to_cnt;
  logic [3:0]  r_bus_cmd;
  logic [3:0]  r_hold_cnt;
  logic        w_per_wrap;
  logic        w_latch;
  logic        w_pkt_end;
  logic        w_tmo;
  logic        w_ovr;
  logic [3:0]  w_sel_dir;
  logic        w_sel_src;
  logic [3:0]  w_hold_nxt;

  // Drop contradictory bit pairs when the sanitize build option is enabled.
  function automatic logic [3:0] sanitize_dir(input logic [3:0] dir);
    logic [3:0] res;
    res = dir;
`ifdef DIR_SANITIZE_EN
    if (dir[0] && dir[1]) res[1:0] = 2'b00;
    if (dir[2] && dir[3]) res[3:2] = 2'b00;
`endif
    return res;
  endfunction

  assign w_per_wrap = (r_per_cnt == LP_PER_LAST);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic plus the single-cycle events (latch, packet end, timeout, overrun).
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_pkt_end   = 1'b0;
    w_tmo       = 1'b0;
    w_ovr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_per_wrap) begin
          w_latch     = 1'b1;
          w_state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        w_state_nxt = S_TX;
      end
      S_TX: begin
        // A slot that falls inside a packet is lost, not deferred.
        w_ovr = w_per_wrap;
        if (i_pkt_done) begin
          w_pkt_end = 1'b1;
        end else if (r_to_cnt == LP_TO_LAST) begin
          w_pkt_end = 1'b1;
          w_tmo     = 1'b1;
        end
        if (w_pkt_end) w_state_nxt = i_enable ? S_WAIT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Direction source selection; a write in the latch cycle itself takes priority.
  always_comb begin
    w_sel_dir  = i_sw_dir;
    w_sel_src  = 1'b0;
    w_hold_nxt = r_hold_cnt;
    if (i_bus_we) begin
      w_sel_dir  = i_bus_dir;
      w_sel_src  = 1'b1;
      w_hold_nxt = LP_HOLD - 4'd1;
    end else if (r_hold_cnt != 4'd0) begin
      w_sel_dir  = r_bus_cmd;
      w_sel_src  = 1'b1;
      w_hold_nxt = r_hold_cnt - 4'd1;
    end
  end

  // Period counter keeps the strobe grid; timeout counter measures age since the latch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_per_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      if (w_state_nxt == S_IDLE || w_per_wrap) r_per_cnt <= '0;
      else                                     r_per_cnt <= r_per_cnt + 24'd1;
      if (w_latch)                                    r_to_cnt <= '0;
      else if (r_state == S_STROBE || r_state == S_TX) r_to_cnt <= r_to_cnt + 24'd1;
    end
  end

  // Bus command store and remaining hold count for bus ownership.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_cmd  <= '0;
      r_hold_cnt <= '0;
    end else begin
      if (i_bus_we) r_bus_cmd <= i_bus_dir;
      if (w_latch)       r_hold_cnt <= w_hold_nxt;
      else if (i_bus_we) r_hold_cnt <= LP_HOLD;
    end
  end

  // Registered outputs: strobe, latched direction, busy, packet count, sticky flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pack_strobe <= 1'b0;
      o_dir_state   <= '0;
      o_src_bus     <= 1'b0;
      o_busy        <= 1'b0;
      o_pkt_count   <= '0;
      o_overrun     <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      o_pack_strobe <= w_latch;
      if (w_latch) begin
        o_dir_state <= sanitize_dir(w_sel_dir);
        o_src_bus   <= w_sel_src;
      end
      if (w_latch)        o_busy <= 1'b1;
      else if (w_pkt_end) o_busy <= 1'b0;
      if (r_state == S_STROBE) o_pkt_count <= o_pkt_count + 8'd1;
      // Set has priority over a simultaneous clear.
      if (w_ovr)          o_overrun <= 1'b1;
      else if (i_err_clr) o_overrun <= 1'b0;
      if (w_tmo)          o_timeout_err <= 1'b1;
      else if (i_err_clr) o_timeout_err <= 1'b0;
    end
  end

endmodule
